// File: rtl/cram_loader.sv
// EBUS diagnostic loader for the 84-bit x 4K control RAM: address/chunk loads, write, readback.
// Define CRAM_VERIFY_EN to add a post-write read-and-compare pass that drives verifyErr.
module cram_loader #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 84,
  parameter int CHUNK_W = 21,
  parameter int RD_LAT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              diagStrobe,
  input  logic [6:0]        diagFunc,
  input  logic [35:0]       ebusIn,
  output logic [35:0]       ebusOut,
  output logic              busy,
  output logic              cramOwn,
  output logic [ADDR_W-1:0] cramAddr,
  output logic [DATA_W-1:0] cramWrData,
  output logic              cramWe,
  input  logic [DATA_W-1:0] cramRdData,
  output logic              overrun,
  output logic              verifyErr
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, WR, VRD, VCMP, RD, CAP} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  rb_q;
  logic [CNT_W-1:0]   lat_cnt;
  logic [CHUNK_W-1:0] rb_chunk;
  logic               unused_bits;

  assign cramAddr    = addr_q;
  assign cramWrData  = data_q;
  assign unused_bits = ^ebusIn[35:CHUNK_W];

`ifdef CRAM_VERIFY_EN
  logic verify_err_q;
  assign verifyErr = verify_err_q;
`else
  assign verifyErr = 1'b0;
`endif

  // Chunk 0 (function 060) is the most significant slice of the CRAM word.
  always_comb begin
    rb_chunk = '0;
    for (int i = 0; i < 4; i++)
      if (diagFunc[1:0] == i[1:0]) rb_chunk = rb_q[DATA_W-1-CHUNK_W*i -: CHUNK_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rb_q    <= '0;
      lat_cnt <= '0;
      ebusOut <= '0;
      busy    <= 1'b0;
      cramOwn <= 1'b0;
      cramWe  <= 1'b0;
      overrun <= 1'b0;
`ifdef CRAM_VERIFY_EN
      verify_err_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (diagStrobe) begin
            case (diagFunc)
              7'o050: begin
                overrun <= 1'b0;
`ifdef CRAM_VERIFY_EN
                verify_err_q <= 1'b0;
`endif
              end
              7'o051: addr_q <= ebusIn[ADDR_W-1:0];
              7'o052, 7'o053, 7'o054, 7'o055: begin
                for (int i = 0; i < 4; i++)
                  if (diagFunc == 7'(42 + i))
                    data_q[DATA_W-1-CHUNK_W*i -: CHUNK_W] <= ebusIn[CHUNK_W-1:0];
              end
              7'o056: begin
                state   <= WR;
                busy    <= 1'b1;
                cramOwn <= 1'b1;
                cramWe  <= 1'b1;
              end
              7'o057: begin
                state   <= RD;
                busy    <= 1'b1;
                cramOwn <= 1'b1;
                lat_cnt <= CNT_W'(RD_LAT - 1);
              end
              7'o060, 7'o061, 7'o062, 7'o063: ebusOut <= {{(36-CHUNK_W){1'b0}}, rb_chunk};
              default: ;
            endcase
          end
        end
        WR: begin
          cramWe <= 1'b0;
`ifdef CRAM_VERIFY_EN
          state   <= VRD;
          lat_cnt <= CNT_W'(RD_LAT - 1);
`else
          state   <= IDLE;
          busy    <= 1'b0;
          cramOwn <= 1'b0;
          addr_q  <= addr_q + 1'b1;
`endif
        end
`ifdef CRAM_VERIFY_EN
        VRD: begin
          if (lat_cnt == '0) state <= VCMP;
          else lat_cnt <= lat_cnt - 1'b1;
        end
        VCMP: begin
          rb_q <= cramRdData;
          if (cramRdData != data_q) verify_err_q <= 1'b1;
          addr_q  <= addr_q + 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
          cramOwn <= 1'b0;
        end
`endif
        RD: begin
          if (lat_cnt == '0) state <= CAP;
          else lat_cnt <= lat_cnt - 1'b1;
        end
        CAP: begin
          rb_q    <= cramRdData;
          state   <= IDLE;
          busy    <= 1'b0;
          cramOwn <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          cramOwn <= 1'b0;
          cramWe  <= 1'b0;
        end
      endcase
      // Any strobe outside IDLE is dropped, including one on a sequence's final cycle.
      if (diagStrobe && state != IDLE) overrun <= 1'b1;
    end
  end

endmodule
